// File: rtl/o_reg_uart_tx_if.sv
// o_reg_uart_tx_if: groups the MPU o_reg input and the UART/status outputs of o_reg_uart_tx.
// master: the side that drives o_reg and observes the line (MPU or bench).
// slave:  the o_reg_uart_tx block itself.
interface o_reg_uart_tx_if #(
    parameter int unsigned FIFO_DEPTH = 8
);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

    logic [3:0]      o_reg;
    logic            tx;
    logic            busy;
    logic [CntW-1:0] fifo_count;
    logic            overflow;

    modport master (
        output o_reg,
        input  tx,
        input  busy,
        input  fifo_count,
        input  overflow
    );

    modport slave (
        input  o_reg,
        output tx,
        output busy,
        output fifo_count,
        output overflow
    );
endinterface

// File: rtl/o_reg_uart_tx.sv
// o_reg_uart_tx: watches the MPU 4-bit o_reg, queues every new value in a small nibble FIFO
// and sends each one as an ASCII hex character over an 8N1 UART line.
// Optional macro O_REG_UART_TX_PARITY_EN inserts an even-parity bit (8E1 framing).
// The interface instance must be built with the same FIFO_DEPTH as this module.
module o_reg_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input logic            clk,
    input logic            reset,
    o_reg_uart_tx_if.slave bus
);
    localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW  = PtrW + 1;

`ifdef O_REG_UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;
`else
    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;
`endif

    // Nibble to ASCII hex character ('0'-'9', 'A'-'F').
    function automatic logic [7:0] encode(input logic [3:0] n);
        if (n <= 4'd9) begin
            return 8'h30 + {4'b0000, n};
        end else begin
            return 8'h37 + {4'b0000, n};
        end
    endfunction

    // State
    logic [3:0]       o_reg_q;
    state_e           state_q, state_d;
    logic [BaudW-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       data_q, data_d;
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [3:0]       mem_q [FIFO_DEPTH];

    // Combinational control
    logic change;
    logic pop;
    logic push_ok;
    logic baud_done;
    logic tx_w;

    assign change    = (bus.o_reg != o_reg_q);
    assign baud_done = (baud_q == BaudW'(CLKS_PER_BIT - 1));

    // Frame sequencing: baud/bit counting and the pop decision taken in IDLE.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        data_d  = data_q;
        pop     = 1'b0;

        // Baud counter free-runs within a frame and wraps at each bit boundary.
        if (state_q != StIdle) begin
            baud_d = baud_done ? '0 : baud_q + BaudW'(1);
        end

        unique case (state_q)
            StIdle: begin
                baud_d = '0;
                bit_d  = '0;
                // Pop decision uses the FIFO state before this edge.
                if (count_q != '0) begin
                    pop     = 1'b1;
                    data_d  = encode(mem_q[rd_ptr_q]);
                    state_d = StStart;
                end
            end
            StStart: begin
                if (baud_done) begin
                    bit_d   = '0;
                    state_d = StData;
                end
            end
            StData: begin
                if (baud_done) begin
                    if (bit_q == 3'd7) begin
`ifdef O_REG_UART_TX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
`ifdef O_REG_UART_TX_PARITY_EN
            StParity: begin
                if (baud_done) begin
                    state_d = StStop;
                end
            end
`endif
            StStop: begin
                if (baud_done) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Serial line value for the current state; idle and stop are high.
    always_comb begin
        tx_w = 1'b1;
        unique case (state_q)
            StIdle:   tx_w = 1'b1;
            StStart:  tx_w = 1'b0;
            StData:   tx_w = data_q[bit_q];
`ifdef O_REG_UART_TX_PARITY_EN
            StParity: tx_w = ^data_q;
`endif
            StStop:   tx_w = 1'b1;
            default:  tx_w = 1'b1;
        endcase
    end

    // FIFO bookkeeping: a full FIFO still accepts a push when the same edge pops.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        push_ok = change && ((count_q < CntW'(FIFO_DEPTH)) || pop);

        if (change && !push_ok) begin
            overflow_d = 1'b1;
        end
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end

        unique case ({push_ok, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control and status registers; reset abandons any frame and flushes the FIFO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_reg_q    <= 4'h0;
            state_q    <= StIdle;
            baud_q     <= '0;
            bit_q      <= '0;
            data_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            o_reg_q    <= bus.o_reg;
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            data_q     <= data_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Nibble storage; contents are only read behind a nonzero count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= bus.o_reg;
        end
    end

    assign bus.tx         = tx_w;
    assign bus.busy       = (state_q != StIdle);
    assign bus.fifo_count = count_q;
    assign bus.overflow   = overflow_q;

endmodule

// File: doc/o_reg_uart_tx.md
Name: o_reg_uart_tx

Overview:
- Output stage that sits directly downstream of the MPU's 4-bit `o_reg`.
- Every time `o_reg` changes value, the block captures the new nibble and queues it in a small FIFO.
- Each queued nibble is sent as one ASCII hex character (`'0'`–`'9'`, `'A'`–`'F'`) over an 8N1 UART line.
- Purpose: host-side observation of program output with no changes to the MPU core.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit time; legal range ≥2.
- FIFO_DEPTH, 8, nibble FIFO entries; must be a power of 2 and ≥2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- o_reg  input  4  MPU output register; already registered in the clk domain, so no synchronizer.
- tx  output  1  UART serial data; idle high.
- busy  output  1  high while a frame is in progress (state != IDLE).
- fifo_count  output  $clog2(FIFO_DEPTH)+1  number of queued nibbles, excluding the nibble being transmitted.
- overflow  output  1  sticky; set when a change is dropped because the FIFO is full; cleared only by reset.

Behaviour:
- Reset (reset low, asynchronous) forces:
  - tx=1, busy=0, fifo_count=0, overflow=0.
  - o_reg_q=0, state=IDLE, bit counter=0, baud counter=0.
  - FIFO read and write pointers = 0.
- Change detect:
  - o_reg_q <= o_reg on every edge.
  - change = (o_reg != o_reg_q).
  - On an edge where change=1, the current o_reg is pushed.
  - Consequence: the first nonzero value after reset produces a push; holding o_reg at 0 after reset does not.
- Push/pop on the same edge:
  - Push is accepted if fifo_count < FIFO_DEPTH, or if a pop occurs on the same edge.
  - Otherwise the nibble is dropped and overflow is set.
  - Simultaneous push and pop leaves fifo_count unchanged.
- Pointers: wrap modulo FIFO_DEPTH. fifo_count is maintained with full width, so full and empty are distinguishable.
- Encoding of nibble n to byte:
  - n ≤ 9: byte = 0x30+n.
  - n ≥ 10: byte = 0x37+n (0xA→0x41, 0xF→0x46).
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If fifo_count>0: pop, load the shift register with the encoded byte, go to START. The FIFO state before this edge determines the pop.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: 8 bits, LSB first, each bit held CLKS_PER_BIT cycles, then go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1, restarts at each state or bit boundary, and is held at 0 in IDLE.
- Latency:
  - A change visible before edge k is pushed at edge k.
  - The frame pops at edge k+1 if the FIFO was empty, so tx falls after edge k+1.
  - A frame lasts 10*CLKS_PER_BIT cycles.
  - Back-to-back frames are separated by exactly 1 IDLE cycle (tx=1).
- Reset mid-frame: tx returns to 1 immediately, the frame is abandoned, and the FIFO is flushed.
- Changes that occur while busy are still detected and queued.

Optional Feature:
- Macro: O_REG_UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - tx = even parity (XOR of the 8 data bits), held CLKS_PER_BIT cycles.
  - Frame becomes 8E1 at 11*CLKS_PER_BIT cycles.
- Undefined: 8N1 framing at 10*CLKS_PER_BIT cycles, with no PARITY state present in the RTL.

Test Plan:
- Reset held low with o_reg toggling → tx=1, busy=0, fifo_count=0, overflow=0 throughout; nothing transmitted after release while o_reg is held at 0.
- CLKS_PER_BIT=4, o_reg 0→5 → tx low 1 cycle after the push edge; frame 0x35 = start 0, data 1,0,1,0,1,1,0,0, stop 1; each bit 4 cycles; busy high 40 cycles.
- o_reg 0→0xA → byte 0x41 (data 1,0,0,0,0,0,1,0); with O_REG_UART_TX_PARITY_EN defined, parity bit=0 and busy high 44 cycles.
- o_reg 1, 2, 3 on consecutive cycles → three frames 0x31, 0x32, 0x33 in order, each separated by exactly 1 idle cycle; fifo_count peaks at 2.
- FIFO_DEPTH=8, 10 distinct changes on consecutive cycles → first popped, next 8 queued, 10th dropped; overflow=1 and stays 1 after the FIFO drains; 9 frames total.
- Reset asserted in mid-DATA with 3 queued → tx=1 asynchronously, fifo_count=0, busy=0; no further frames after release.
